// File: rtl/bd_if_pkg.sv
// Shared widths and word types for the BD pin-receiver / FPGA-core channel path.
package bd_if_pkg;
    localparam int NUM_BITS_PIN2CORE = 21;
    localparam int NUM_BITS_CORE2PIN = 34;

    typedef logic [NUM_BITS_CORE2PIN-1:0] bd_out_word_t;
    typedef logic [NUM_BITS_PIN2CORE-1:0] bd_in_word_t;
endpackage

// File: rtl/bd_channel_fifo_if.sv
// Channel v/a link: the producer drives d/v, the consumer returns a one-cycle accept pulse.
interface bd_channel_if
    import bd_if_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_CORE2PIN
);
    logic [NUM_BITS-1:0] d;
    logic                v;
    logic                a;

    modport master (output d, v, input a);
    modport slave  (input d, v, output a);
endinterface

// File: rtl/bd_fifo_mem.sv
// Word storage: one synchronous write port, one asynchronous read port, no reset.
module bd_fifo_mem
    import bd_if_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_CORE2PIN,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [NUM_BITS-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [NUM_BITS-1:0] rdata
);
    logic [NUM_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/bd_channel_fifo.sv
// Elastic channel-to-channel FIFO between the BD pin receiver and the core decoder,
// with occupancy, high-water mark and a sticky pop-while-empty error flag.
module bd_channel_fifo
    import bd_if_pkg::*;
#(
    parameter  int NUM_BITS = NUM_BITS_CORE2PIN,
    parameter  int DEPTH    = 16,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    bd_channel_if.slave   in_channel,
    bd_channel_if.master  out_channel,
    output logic [CW-1:0] count,
    output logic [CW-1:0] high_water,
    input  logic          clear_hw,
    output logic          proto_err
);
    localparam int PW = CW - 1;

    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       hw_q, hw_d;
    logic                acc_q, acc_d;
    logic                err_q, err_d;
    logic                full, empty, push, pop;
    logic [NUM_BITS-1:0] rdata;

    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        // acc_q masks the accept cycle, where the producer still holds the same word
        push  = in_channel.v & ~acc_q & ~full;
        pop   = out_channel.a & ~empty;

        acc_d    = push;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        err_d    = err_q | (out_channel.a & empty);

        hw_d = hw_q;
        if (clear_hw)           hw_d = count_d;
        else if (count_d > hw_q) hw_d = count_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hw_q     <= '0;
            acc_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hw_q     <= hw_d;
            acc_q    <= acc_d;
            err_q    <= err_d;
        end
    end

    bd_fifo_mem #(
        .NUM_BITS (NUM_BITS),
        .DEPTH    (DEPTH),
        .AW       (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_channel.d),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Head word is forced to zero while empty so idle output is deterministic
    assign out_channel.v = ~empty;
    assign out_channel.d = empty ? '0 : rdata;
    assign in_channel.a  = acc_q;
    assign count         = count_q;
    assign high_water    = hw_q;
    assign proto_err     = err_q;
endmodule

// File: tb/tb_bd_channel_fifo.sv
// Directed + random bench for bd_channel_fifo against a queue-based model.
module tb_bd_channel_fifo;
    import bd_if_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear_hw = 1'b0;
    logic [CW-1:0] count, high_water;
    logic          proto_err;

    bd_channel_if #(.NUM_BITS(NUM_BITS_CORE2PIN)) in_if ();
    bd_channel_if #(.NUM_BITS(NUM_BITS_CORE2PIN)) out_if ();

    bd_channel_fifo #(.NUM_BITS(NUM_BITS_CORE2PIN), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_channel  (in_if),
        .out_channel (out_if),
        .count       (count),
        .high_water  (high_water),
        .clear_hw    (clear_hw),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    // Reference model: ordered queue of stored words plus the observable flags
    bd_out_word_t q[$];
    bit           m_acc;
    bit           m_err;
    int           m_hw;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".in_a"},  64'(in_if.a),   64'(m_acc));
        chk({tag, ".out_v"}, 64'(out_if.v),  64'(q.size() != 0));
        chk({tag, ".out_d"}, 64'(out_if.d),  (q.size() != 0) ? 64'(q[0]) : 64'd0);
        chk({tag, ".count"}, 64'(count),     64'(q.size()));
        chk({tag, ".hw"},    64'(high_water), 64'(m_hw));
        chk({tag, ".err"},   64'(proto_err), 64'(m_err));
    endtask

    // Apply the channel rules to the inputs present before the coming edge
    task automatic model_edge();
        bit push, pop;
        push = in_if.v && !m_acc && (q.size() < DEPTH);
        pop  = out_if.a && (q.size() > 0);
        if (out_if.a && q.size() == 0) m_err = 1'b1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(in_if.d);
        m_acc = push;
        if (clear_hw)             m_hw = q.size();
        else if (q.size() > m_hw) m_hw = q.size();
    endtask

    task automatic step(string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        q.delete();
        m_acc = 1'b0;
        m_err = 1'b0;
        m_hw  = 0;
        check_all({tag, ".asserted"});
        in_if.v  = 1'b0;
        out_if.a = 1'b0;
        clear_hw = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all({tag, ".released"});
    endtask

    // One word offered and held through its accept cycle
    task automatic offer(bd_out_word_t w, string tag);
        in_if.v = 1'b1;
        in_if.d = w;
        step({tag, ".push"});
        step({tag, ".acc"});
        in_if.v = 1'b0;
    endtask

    task automatic pulse_pop(string tag);
        out_if.a = 1'b1;
        step({tag, ".pop"});
        out_if.a = 1'b0;
        step({tag, ".idle"});
    endtask

    task automatic drain(string tag);
        for (int k = 0; k < 2 * DEPTH && q.size() != 0; k++) pulse_pop(tag);
        chk({tag, ".drained"}, 64'(count), 64'd0);
    endtask

    function automatic bd_out_word_t rnd_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[NUM_BITS_CORE2PIN-1:0];
    endfunction

    initial begin
        bit a_seen;
        in_if.v  = 1'b0;
        in_if.d  = '0;
        out_if.a = 1'b0;
        do_reset("por");

        // Reset in the middle of a burst, with an accept pulse outstanding
        for (int i = 0; i < 3; i++) offer(34'h100 + 34'(i), "burst");
        in_if.v = 1'b1;
        in_if.d = 34'h1_2345_6789;
        step("burst.w3");
        do_reset("midreset");
        offer(34'h1_2345_6789, "reoffer");
        drain("reoffer");

        // Single word, then a producer holding v through the accept cycle
        offer(34'h2_DEAD_BEEF, "single");
        drain("single");
        in_if.v = 1'b1;
        in_if.d = 34'h0_CAFE_F00D;
        step("hold.c0");
        step("hold.c1");
        in_if.v = 1'b0;
        step("hold.c2");
        drain("hold");

        // Fill to full; word 16 waits until a slot frees
        do_reset("prefill");
        for (int i = 0; i < DEPTH; i++) offer(34'(i), "fill");
        in_if.v = 1'b1;
        in_if.d = 34'd16;
        step("full.blk0");
        step("full.blk1");
        out_if.a = 1'b1;
        step("full.pop");
        out_if.a = 1'b0;
        step("full.push16");
        step("full.acc16");
        in_if.v = 1'b0;
        drain("full");

        // Simultaneous push and pop at count 5, then clear_hw
        for (int i = 0; i < 5; i++) offer(34'h200 + 34'(i), "pp.fill");
        in_if.v  = 1'b1;
        in_if.d  = 34'h3_0000_0005;
        out_if.a = 1'b1;
        step("pp.both");
        out_if.a = 1'b0;
        step("pp.acc");
        in_if.v  = 1'b0;
        clear_hw = 1'b1;
        step("pp.clrhw");
        clear_hw = 1'b0;
        step("pp.after");
        drain("pp");

        // Pop while empty sets the sticky error; storage keeps working
        out_if.a = 1'b1;
        step("empty.pop");
        out_if.a = 1'b0;
        step("empty.idle");
        offer(34'h1_5A5A_A5A5, "empty.push");
        drain("empty");

        // Random traffic, producer and consumer both obeying the channel rules
        a_seen = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (c == 400) begin
                do_reset("rnd.reset");
                a_seen = 1'b0;
            end
            if (a_seen || !in_if.v) begin
                in_if.v = ($urandom_range(2, 0) != 0);
                in_if.d = rnd_word();
            end
            out_if.a = !out_if.a && ($urandom_range(2, 0) == 0);
            clear_hw = ($urandom_range(15, 0) == 0);
            step("rnd");
            a_seen = m_acc;
        end
        in_if.v  = 1'b0;
        out_if.a = 1'b0;
        clear_hw = 1'b0;
        step("rnd.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
